// File: rtl/datapath_pkg.sv
// Shared definitions for the datapath sequencer: opcodes, ALU function selects,
// ControlWord field positions and the sequencer state encoding.
package datapath_pkg;

  localparam int CW_W = 55;

  localparam int CW_DA_LSB  = 52;
  localparam int CW_AA_LSB  = 49;
  localparam int CW_BA_LSB  = 46;
  localparam int CW_MB      = 45;
  localparam int CW_FS_LSB  = 41;
  localparam int CW_SHT_LSB = 38;
  localparam int CW_SHA_LSB = 34;
  localparam int CW_MD      = 33;
  localparam int CW_RW      = 32;
  localparam int CW_CB_LSB  = 16;
  localparam int CW_CD_LSB  = 0;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_ADDI  = 4'h6;
  localparam logic [3:0] OP_SUBI  = 4'h7;
  localparam logic [3:0] OP_LDI   = 4'h8;
  localparam logic [3:0] OP_MOV   = 4'h9;
  localparam logic [3:0] OP_CMP   = 4'hA;
  localparam logic [3:0] OP_CMOVZ = 4'hB;
  localparam logic [3:0] OP_SWAP  = 4'hC;
  localparam logic [3:0] OP_ILL   = 4'hD;

  localparam logic [3:0] FS_PASSA = 4'h0;
  localparam logic [3:0] FS_ADD   = 4'h2;
  localparam logic [3:0] FS_SUB   = 4'h5;
  localparam logic [3:0] FS_AND   = 4'h8;
  localparam logic [3:0] FS_OR    = 4'h9;
  localparam logic [3:0] FS_XOR   = 4'hA;

  localparam logic [2:0] SH_NONE = 3'b000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_SWAP1,
    ST_SWAP2
  } seqState_e;

  // ALU function for the register-register opcodes ADD..XOR
  function automatic logic [3:0] aluFs(input logic [3:0] op);
    case (op)
      OP_ADD:  aluFs = FS_ADD;
      OP_SUB:  aluFs = FS_SUB;
      OP_AND:  aluFs = FS_AND;
      OP_OR:   aluFs = FS_OR;
      default: aluFs = FS_XOR;
    endcase
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational decode of one instruction (and SWAP micro-step) into the
// ControlWord that the datapath will execute next.
module instr_decoder
  import datapath_pkg::*;
(
  input  logic [31:0]     instr_i,
  input  logic [1:0]      step_i,
  input  logic            zero_i,
  output logic [CW_W-1:0] cw_o,
  output logic            sets_flags_o,
  output logic            is_multi_o
);

  logic [3:0]  op;
  logic [2:0]  rd;
  logic [2:0]  ra;
  logic [2:0]  rb;
  logic [2:0]  shtype;
  logic [15:0] imm;

  assign op     = instr_i[31:28];
  assign rd     = instr_i[27:25];
  assign ra     = instr_i[24:22];
  assign rb     = instr_i[21:19];
  assign shtype = instr_i[18:16];
  assign imm    = instr_i[15:0];

  // zero_i is the Z value CMOVZ sees at acceptance, already forwarded by the top
  always_comb begin
    cw_o         = '0;
    sets_flags_o = 1'b0;
    is_multi_o   = 1'b0;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
        cw_o[CW_DA_LSB +: 3]  = rd;
        cw_o[CW_AA_LSB +: 3]  = ra;
        cw_o[CW_BA_LSB +: 3]  = rb;
        cw_o[CW_FS_LSB +: 4]  = aluFs(op);
        cw_o[CW_SHT_LSB +: 3] = shtype;
        cw_o[CW_SHA_LSB +: 4] = imm[3:0];
        cw_o[CW_RW]           = 1'b1;
        sets_flags_o          = 1'b1;
      end
      OP_ADDI, OP_SUBI: begin
        cw_o[CW_DA_LSB +: 3]  = rd;
        cw_o[CW_AA_LSB +: 3]  = ra;
        cw_o[CW_MB]           = 1'b1;
        cw_o[CW_FS_LSB +: 4]  = (op == OP_ADDI) ? FS_ADD : FS_SUB;
        cw_o[CW_SHT_LSB +: 3] = SH_NONE;
        cw_o[CW_CB_LSB +: 16] = imm;
        cw_o[CW_RW]           = 1'b1;
        sets_flags_o          = 1'b1;
      end
      OP_LDI: begin
        cw_o[CW_DA_LSB +: 3]  = rd;
        cw_o[CW_MD]           = 1'b1;
        cw_o[CW_CD_LSB +: 16] = imm;
        cw_o[CW_RW]           = 1'b1;
      end
      OP_MOV: begin
        cw_o[CW_DA_LSB +: 3] = rd;
        cw_o[CW_AA_LSB +: 3] = ra;
        cw_o[CW_FS_LSB +: 4] = FS_PASSA;
        cw_o[CW_RW]          = 1'b1;
      end
      OP_CMP: begin
        cw_o[CW_AA_LSB +: 3]  = ra;
        cw_o[CW_BA_LSB +: 3]  = rb;
        cw_o[CW_FS_LSB +: 4]  = FS_SUB;
        cw_o[CW_SHT_LSB +: 3] = shtype;
        cw_o[CW_SHA_LSB +: 4] = imm[3:0];
        sets_flags_o          = 1'b1;
      end
      OP_CMOVZ: begin
        if (zero_i) begin
          cw_o[CW_DA_LSB +: 3] = rd;
          cw_o[CW_AA_LSB +: 3] = ra;
          cw_o[CW_FS_LSB +: 4] = FS_PASSA;
          cw_o[CW_RW]          = 1'b1;
        end
      end
      OP_SWAP: begin
        // XOR swap: rd^=ra, ra^=rd, rd^=ra; a self-swap degenerates to a NOP
        if (rd != ra) begin
          is_multi_o           = 1'b1;
          cw_o[CW_DA_LSB +: 3] = (step_i == 2'd1) ? ra : rd;
          cw_o[CW_AA_LSB +: 3] = rd;
          cw_o[CW_BA_LSB +: 3] = ra;
          cw_o[CW_FS_LSB +: 4] = FS_XOR;
          cw_o[CW_RW]          = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/datapath_sequencer.sv
// Instruction sequencer: accepts instructions, registers one ControlWord per
// cycle, owns the condition flags and steps SWAP through its three micro-steps.
module datapath_sequencer
  import datapath_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [31:0]     instr,
  input  logic            Overflow,
  input  logic            CarryOut,
  input  logic            Negative,
  input  logic            Zero,
  output logic [CW_W-1:0] ControlWord,
  output logic [3:0]      flags_q,
  output logic            busy,
  output logic            retire,
  output logic            illegal
);

  seqState_e       state_q, state_d;
  logic [CW_W-1:0] cw_q, cw_d;
  logic [31:0]     instr_q, instr_d;
  logic            multi_q, multi_d;
  logic            setsFlags_q, setsFlags_d;
  logic            retire_q, retire_d;
  logic            illegal_q, illegal_d;
  logic [3:0]      flags_d;

  logic            accept;
  logic            useSaved;
  logic [31:0]     decInstr;
  logic [1:0]      decStep;
  logic            decZero;
  logic [CW_W-1:0] decCw;
  logic            decSets;
  logic            decMulti;

  assign instr_ready = (state_q == ST_IDLE) || (state_q == ST_SWAP2) ||
                       ((state_q == ST_EXEC) && !multi_q);
  assign accept      = instr_valid && instr_ready;

  // SWAP steps 1 and 2 re-decode the saved instruction instead of the input bus
  assign useSaved = ((state_q == ST_EXEC) && multi_q) || (state_q == ST_SWAP1);
  assign decInstr = useSaved ? instr_q : instr;
  assign decStep  = (state_q == ST_SWAP1) ? 2'd2 : (useSaved ? 2'd1 : 2'd0);
  assign decZero  = ((state_q != ST_IDLE) && setsFlags_q) ? Zero : flags_q[0];

  instr_decoder u_decoder (
    .instr_i      (decInstr),
    .step_i       (decStep),
    .zero_i       (decZero),
    .cw_o         (decCw),
    .sets_flags_o (decSets),
    .is_multi_o   (decMulti)
  );

  always_comb begin
    state_d     = ST_IDLE;
    cw_d        = '0;
    instr_d     = instr_q;
    multi_d     = 1'b0;
    setsFlags_d = 1'b0;
    retire_d    = 1'b0;
    illegal_d   = 1'b0;
    flags_d     = flags_q;

    if ((state_q != ST_IDLE) && setsFlags_q) begin
      flags_d = {Overflow, CarryOut, Negative, Zero};
    end

    case (state_q)
      ST_EXEC: begin
        if (multi_q) begin
          state_d = ST_SWAP1;
          cw_d    = decCw;
          multi_d = 1'b1;
        end
      end
      ST_SWAP1: begin
        state_d  = ST_SWAP2;
        cw_d     = decCw;
        multi_d  = 1'b1;
        retire_d = 1'b1;
      end
      default: ;
    endcase

    if (accept) begin
      state_d     = ST_EXEC;
      cw_d        = decCw;
      instr_d     = instr;
      multi_d     = decMulti;
      setsFlags_d = decSets;
      retire_d    = !decMulti;
      illegal_d   = (instr[31:28] >= OP_ILL);
    end
  end

  // Async reset clears the ControlWord at once, so a mid-SWAP reset writes nothing more
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cw_q        <= '0;
      instr_q     <= '0;
      multi_q     <= 1'b0;
      setsFlags_q <= 1'b0;
      retire_q    <= 1'b0;
      illegal_q   <= 1'b0;
      flags_q     <= 4'b0000;
    end else begin
      state_q     <= state_d;
      cw_q        <= cw_d;
      instr_q     <= instr_d;
      multi_q     <= multi_d;
      setsFlags_q <= setsFlags_d;
      retire_q    <= retire_d;
      illegal_q   <= illegal_d;
      flags_q     <= flags_d;
    end
  end

  assign ControlWord = cw_q;
  assign busy        = (state_q != ST_IDLE);
  assign retire      = retire_q;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_datapath_sequencer.sv
// Randomized bench for datapath_sequencer: a simple datapath model closes the
// flag loop, and an instruction-level reference predicts every cycle.
module tb_datapath_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic        Overflow, CarryOut, Negative, Zero;
  logic [54:0] ControlWord;
  logic [3:0]  flags_q;
  logic        busy, retire, illegal;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [54:0] cw;
    logic        ret;
    logic        ill;
    logic [3:0]  flg;
  } step_t;

  step_t       expQ[$];
  logic [15:0] refRegs [8];
  logic [3:0]  refFlags;
  logic [15:0] tbRegs [8] = '{default: 16'h0};

  datapath_sequencer dut (
    .clk         (clk),
    .rst         (rst),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .Overflow    (Overflow),
    .CarryOut    (CarryOut),
    .Negative    (Negative),
    .Zero        (Zero),
    .ControlWord (ControlWord),
    .flags_q     (flags_q),
    .busy        (busy),
    .retire      (retire),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  // Datapath stand-in: executes whatever ControlWord holds (shifts unused, SH_NONE only)
  logic [15:0] dpA, dpB, dpRes;
  logic [16:0] dpWide;
  always_comb begin
    dpA      = tbRegs[ControlWord[51:49]];
    dpB      = ControlWord[45] ? ControlWord[31:16] : tbRegs[ControlWord[48:46]];
    dpWide   = 17'h0;
    dpRes    = dpA;
    Overflow = 1'b0;
    CarryOut = 1'b0;
    case (ControlWord[44:41])
      4'h2: begin
        dpWide   = {1'b0, dpA} + {1'b0, dpB};
        dpRes    = dpWide[15:0];
        CarryOut = dpWide[16];
        Overflow = (dpA[15] == dpB[15]) && (dpRes[15] != dpA[15]);
      end
      4'h5: begin
        dpWide   = {1'b0, dpA} + {1'b0, ~dpB} + 17'd1;
        dpRes    = dpWide[15:0];
        CarryOut = dpWide[16];
        Overflow = (dpA[15] != dpB[15]) && (dpRes[15] != dpA[15]);
      end
      4'h8: dpRes = dpA & dpB;
      4'h9: dpRes = dpA | dpB;
      4'hA: dpRes = dpA ^ dpB;
      default: dpRes = dpA;
    endcase
    Negative = dpRes[15];
    Zero     = (dpRes == 16'h0);
  end

  always @(posedge clk) begin
    if (ControlWord[32]) begin
      tbRegs[ControlWord[54:52]] <= ControlWord[33] ? ControlWord[15:0] : dpRes;
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                      input logic [2:0] ra, input logic [2:0] rb,
                                      input logic [15:0] imm);
    return {op, rd, ra, rb, 3'b000, imm};
  endfunction

  function automatic logic [54:0] mkCw(input logic [2:0] da, input logic [2:0] aa,
                                       input logic [2:0] ba, input logic mb,
                                       input logic [3:0] fs, input logic [3:0] sha,
                                       input logic md, input logic rw,
                                       input logic [15:0] cb, input logic [15:0] cd);
    return {da, aa, ba, mb, fs, 3'b000, sha, md, rw, cb, cd};
  endfunction

  // kind: 0 add, 1 sub, 2 and, 3 or, 4 xor
  task automatic aluRef(input int kind, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output logic [3:0] f);
    int  s, sv;
    logic v, c;
    v = 1'b0;
    c = 1'b0;
    case (kind)
      0: begin
        s  = int'(a) + int'(b);
        r  = s[15:0];
        c  = (s > 65535);
        sv = int'($signed(a)) + int'($signed(b));
        v  = (sv > 32767) || (sv < -32768);
      end
      1: begin
        r  = a - b;
        c  = (a >= b);
        sv = int'($signed(a)) - int'($signed(b));
        v  = (sv > 32767) || (sv < -32768);
      end
      2: r = a & b;
      3: r = a | b;
      default: r = a ^ b;
    endcase
    f = {v, c, r[15], (r == 16'h0)};
  endtask

  // Instruction-level reference: expected micro-steps plus architectural state update
  task automatic modelInstr(input logic [31:0] ins);
    logic [3:0]  op, fs, nf;
    logic [2:0]  rd, ra, rb;
    logic [15:0] imm, a, b, r, t;
    step_t       st;
    op  = ins[31:28];
    rd  = ins[27:25];
    ra  = ins[24:22];
    rb  = ins[21:19];
    imm = ins[15:0];
    a   = refRegs[ra];
    b   = refRegs[rb];
    st  = '{cw: 55'h0, ret: 1'b1, ill: 1'b0, flg: refFlags};
    case (op)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
        case (op)
          4'h1: fs = 4'h2;
          4'h2: fs = 4'h5;
          4'h3: fs = 4'h8;
          4'h4: fs = 4'h9;
          default: fs = 4'hA;
        endcase
        st.cw = mkCw(rd, ra, rb, 1'b0, fs, imm[3:0], 1'b0, 1'b1, 16'h0, 16'h0);
        aluRef(int'(op) - 1, a, b, r, nf);
        refRegs[rd] = r;
        refFlags    = nf;
      end
      4'h6, 4'h7: begin
        st.cw = mkCw(rd, ra, 3'd0, 1'b1, (op == 4'h6) ? 4'h2 : 4'h5, 4'h0, 1'b0, 1'b1, imm, 16'h0);
        aluRef((op == 4'h6) ? 0 : 1, a, imm, r, nf);
        refRegs[rd] = r;
        refFlags    = nf;
      end
      4'h8: begin
        st.cw = mkCw(rd, 3'd0, 3'd0, 1'b0, 4'h0, 4'h0, 1'b1, 1'b1, 16'h0, imm);
        refRegs[rd] = imm;
      end
      4'h9: begin
        st.cw = mkCw(rd, ra, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'h0, 16'h0);
        refRegs[rd] = a;
      end
      4'hA: begin
        st.cw = mkCw(3'd0, ra, rb, 1'b0, 4'h5, imm[3:0], 1'b0, 1'b0, 16'h0, 16'h0);
        aluRef(1, a, b, r, nf);
        refFlags = nf;
      end
      4'hB: begin
        if (refFlags[0]) begin
          st.cw = mkCw(rd, ra, 3'd0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b1, 16'h0, 16'h0);
          refRegs[rd] = a;
        end
      end
      4'hC: begin
        if (rd != ra) begin
          st.ret = 1'b0;
          st.cw  = mkCw(rd, rd, ra, 1'b0, 4'hA, 4'h0, 1'b0, 1'b1, 16'h0, 16'h0);
          expQ.push_back(st);
          st.cw  = mkCw(ra, rd, ra, 1'b0, 4'hA, 4'h0, 1'b0, 1'b1, 16'h0, 16'h0);
          expQ.push_back(st);
          st.ret = 1'b1;
          st.cw  = mkCw(rd, rd, ra, 1'b0, 4'hA, 4'h0, 1'b0, 1'b1, 16'h0, 16'h0);
          t = refRegs[rd];
          refRegs[rd] = refRegs[ra];
          refRegs[ra] = t;
        end
      end
      4'hD, 4'hE, 4'hF: st.ill = 1'b1;
      default: ;
    endcase
    expQ.push_back(st);
  endtask

  task automatic applyStimulus(input logic [31:0] ins);
    instr_valid = 1'b1;
    instr       = ins;
    modelInstr(ins);
  endtask

  task automatic driveIdle();
    instr_valid = 1'b0;
    instr       = $urandom;
  endtask

  task automatic driveBlocked();
    instr_valid = 1'($urandom_range(0, 1));
    instr       = $urandom;
  endtask

  task automatic checkCycle();
    step_t s;
    logic  expReady;
    if (expQ.size() > 0) begin
      s = expQ.pop_front();
      checkOutput("cw", 64'(ControlWord), 64'(s.cw));
      checkOutput("busy", 64'(busy), 64'd1);
      checkOutput("retire", 64'(retire), 64'(s.ret));
      checkOutput("illegal", 64'(illegal), 64'(s.ill));
      checkOutput("flags", 64'(flags_q), 64'(s.flg));
    end else begin
      checkOutput("cw_idle", 64'(ControlWord), 64'd0);
      checkOutput("busy_idle", 64'(busy), 64'd0);
      checkOutput("retire_idle", 64'(retire), 64'd0);
      checkOutput("illegal_idle", 64'(illegal), 64'd0);
      checkOutput("flags_idle", 64'(flags_q), 64'(refFlags));
    end
    expReady = (expQ.size() == 0);
    checkOutput("ready", 64'(instr_ready), 64'(expReady));
  endtask

  task automatic drainAndCompare(input string tag);
    repeat (4) begin
      @(negedge clk);
      checkCycle();
      driveIdle();
    end
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("%s_r%0d", tag, i), 64'(tbRegs[i]), 64'(refRegs[i]));
    end
  endtask

  function automatic logic [31:0] randInstr();
    logic [2:0] ra, rb;
    ra = 3'($urandom_range(0, 7));
    rb = ($urandom_range(0, 3) == 0) ? ra : 3'($urandom_range(0, 7));
    return enc(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), ra, rb, 16'($urandom));
  endfunction

  logic [31:0] dirList[$];
  logic [15:0] old6, old7;
  int          idx;

  initial begin
    for (int i = 0; i < 8; i++) refRegs[i] = 16'h0;
    refFlags    = 4'b0000;
    rst         = 1'b1;
    instr_valid = 1'b0;
    instr       = 32'h0;

    repeat (2) @(negedge clk);
    checkOutput("rst_cw", 64'(ControlWord), 64'd0);
    checkOutput("rst_flags", 64'(flags_q), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_retire", 64'(retire), 64'd0);
    checkOutput("rst_illegal", 64'(illegal), 64'd0);
    checkOutput("rst_ready", 64'(instr_ready), 64'd1);
    rst = 1'b0;

    dirList.push_back(enc(4'h8, 3'd1, 3'd0, 3'd0, 16'h1234));
    dirList.push_back(enc(4'h1, 3'd2, 3'd1, 3'd1, 16'h0000));
    dirList.push_back(enc(4'h7, 3'd3, 3'd2, 3'd0, 16'h0001));
    dirList.push_back(enc(4'hA, 3'd0, 3'd1, 3'd1, 16'h0000));
    dirList.push_back(enc(4'hB, 3'd4, 3'd1, 3'd0, 16'h0000));
    dirList.push_back(enc(4'hA, 3'd0, 3'd1, 3'd3, 16'h0000));
    dirList.push_back(enc(4'hB, 3'd5, 3'd1, 3'd0, 16'h0000));
    dirList.push_back(enc(4'hC, 3'd1, 3'd3, 3'd0, 16'h0000));
    dirList.push_back(enc(4'hC, 3'd2, 3'd2, 3'd0, 16'h0000));
    dirList.push_back(enc(4'hE, 3'd6, 3'd1, 3'd2, 16'hFFFF));

    idx = 0;
    while (idx < dirList.size()) begin
      @(negedge clk);
      checkCycle();
      if (expQ.size() == 0) begin
        applyStimulus(dirList[idx]);
        idx++;
      end else begin
        driveBlocked();
      end
    end
    drainAndCompare("dir");
    checkOutput("dir_r1_swapped", 64'(tbRegs[1]), 64'h2467);
    checkOutput("dir_r3_swapped", 64'(tbRegs[3]), 64'h1234);
    checkOutput("dir_r4_cmovz", 64'(tbRegs[4]), 64'h1234);

    repeat (1500) begin
      @(negedge clk);
      checkCycle();
      if (expQ.size() != 0) driveBlocked();
      else if ($urandom_range(0, 3) != 0) applyStimulus(randInstr());
      else driveIdle();
    end
    drainAndCompare("rnd");

    // Reset landing in the SWAP1 cycle: only step 0 has been written back
    @(negedge clk);
    checkCycle();
    old6 = refRegs[6];
    old7 = refRegs[7];
    applyStimulus(enc(4'hC, 3'd6, 3'd7, 3'd0, 16'h0000));
    @(negedge clk);
    checkCycle();
    driveIdle();
    @(negedge clk);
    checkCycle();
    instr_valid = 1'b1;
    instr       = enc(4'h8, 3'd0, 3'd0, 3'd0, 16'hBEEF);
    #2 rst = 1'b1;
    #1;
    checkOutput("abort_cw", 64'(ControlWord), 64'd0);
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_retire", 64'(retire), 64'd0);
    checkOutput("abort_flags", 64'(flags_q), 64'd0);
    checkOutput("abort_ready", 64'(instr_ready), 64'd1);
    expQ.delete();
    refRegs[6] = old6 ^ old7;
    refRegs[7] = old7;
    refFlags   = 4'b0000;
    @(negedge clk);
    rst = 1'b0;
    driveIdle();
    @(negedge clk);
    checkCycle();
    applyStimulus(enc(4'h8, 3'd5, 3'd0, 3'd0, 16'h5A5A));
    drainAndCompare("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
